// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned LOC_W = 2;
  localparam int unsigned BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [LOC_W-1:0] LOC_MIN_LO = 2'd0;
  localparam logic [LOC_W-1:0] LOC_MIN_HI = 2'd1;
  localparam logic [LOC_W-1:0] LOC_HR_LO  = 2'd2;
  localparam logic [LOC_W-1:0] LOC_HR_HI  = 2'd3;

  localparam logic [AN_W-1:0] AN_OFF = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment glyph; codes above 9 decode to blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit HH:MM multiplexed display driver with anti-ghost blanking and edit blink.
// Optional: define LEAD_ZERO_BLANK_EN to suppress a leading hour zero outside setup.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 49999,
  parameter int unsigned BLINK_DIV = 24999999,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setupMode,
  input  logic [LOC_W-1:0] editDigit,
  input  logic [BCD_W-1:0] hourUpper,
  input  logic [BCD_W-1:0] hourLower,
  input  logic [BCD_W-1:0] minuteUpper,
  input  logic [BCD_W-1:0] minuteLower,
  input  logic [5:0]       secondCounter,
  output logic [AN_W-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [LOC_W-1:0] loc
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 0) ? $clog2(SCAN_DIV + 1)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;
  localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);

  if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("BLANK_CYC must satisfy 1 <= BLANK_CYC < SCAN_DIV");
  end

  scan_state_e        r_state;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [LOC_W-1:0]   r_loc;
  logic [AN_W-1:0]    r_an;
  logic [SEG_W-1:0]   r_seg;
  logic               r_dp;

  scan_state_e        w_next_state;
  logic [SCAN_W-1:0]  w_next_scan_cnt;
  logic [BLANK_W-1:0] w_next_blank_cnt;
  logic [BLINK_W-1:0] w_next_blink_cnt;
  logic               w_next_blink_phase;
  logic [LOC_W-1:0]   w_next_loc;
  logic               w_scan_tick;
  logic [BCD_W-1:0]   w_digit;
  logic [SEG_W-1:0]   w_glyph;
  logic               w_digit_blank;
  logic [AN_W-1:0]    w_next_an;
  logic [SEG_W-1:0]   w_next_seg;
  logic               w_next_dp;
  logic               w_unused_sec;

  assign w_unused_sec = ^secondCounter[5:1];

  // Free-running scan prescaler; the wrap cycle is the scan tick.
  always_comb begin
    w_scan_tick     = (r_scan_cnt == SCAN_W'(SCAN_DIV));
    w_next_scan_cnt = w_scan_tick ? '0 : SCAN_W'(r_scan_cnt + SCAN_W'(1));
  end

  // Slot sequencing: a tick always restarts blanking on the next position.
  always_comb begin
    w_next_state     = r_state;
    w_next_loc       = r_loc;
    w_next_blank_cnt = r_blank_cnt;
    if (w_scan_tick) begin
      w_next_state     = BLANK;
      w_next_loc       = LOC_W'(r_loc + LOC_W'(1));
      w_next_blank_cnt = '0;
    end else if (r_state == BLANK) begin
      if (r_blank_cnt == BLANK_W'(BLANK_CYC - 1)) begin
        w_next_state     = DRIVE;
        w_next_blank_cnt = '0;
      end else begin
        w_next_blank_cnt = BLANK_W'(r_blank_cnt + BLANK_W'(1));
      end
    end
  end

  // Blink timebase only runs in setup so editing starts with the digit visible.
  always_comb begin
    w_next_blink_cnt   = '0;
    w_next_blink_phase = 1'b0;
    if (setupMode) begin
      if (r_blink_cnt == BLINK_W'(BLINK_DIV)) begin
        w_next_blink_cnt   = '0;
        w_next_blink_phase = ~r_blink_phase;
      end else begin
        w_next_blink_cnt   = BLINK_W'(r_blink_cnt + BLINK_W'(1));
        w_next_blink_phase = r_blink_phase;
      end
    end
  end

  always_comb begin
    w_digit = minuteLower;
    case (w_next_loc)
      LOC_MIN_LO: w_digit = minuteLower;
      LOC_MIN_HI: w_digit = minuteUpper;
      LOC_HR_LO:  w_digit = hourLower;
      LOC_HR_HI:  w_digit = hourUpper;
      default:    w_digit = minuteLower;
    endcase
  end

  seg7_decode u_decode (
    .i_bcd   (w_digit),
    .o_seg_c (w_glyph)
  );

  // Output images are built from next-state values so the pins track the registered slot.
  always_comb begin
    w_digit_blank = setupMode && w_next_blink_phase && (w_next_loc == editDigit);
`ifdef LEAD_ZERO_BLANK_EN
    if (!setupMode && (w_next_loc == LOC_HR_HI) && (hourUpper == 4'd0)) begin
      w_digit_blank = 1'b1;
    end
`endif
    w_next_an  = AN_OFF;
    w_next_seg = SEG_BLANK;
    w_next_dp  = 1'b1;
    if (w_next_state == DRIVE) begin
      w_next_an  = AN_W'(~(AN_W'(1) << w_next_loc));
      w_next_seg = w_digit_blank ? SEG_BLANK : w_glyph;
      if (w_next_loc == LOC_HR_LO) begin
        w_next_dp = setupMode ? 1'b0 : secondCounter[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= BLANK;
      r_scan_cnt    <= '0;
      r_blank_cnt   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_loc         <= LOC_MIN_LO;
      r_an          <= AN_OFF;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
    end else begin
      r_state       <= w_next_state;
      r_scan_cnt    <= w_next_scan_cnt;
      r_blank_cnt   <= w_next_blank_cnt;
      r_blink_cnt   <= w_next_blink_cnt;
      r_blink_phase <= w_next_blink_phase;
      r_loc         <= w_next_loc;
      r_an          <= w_next_an;
      r_seg         <= w_next_seg;
      r_dp          <= w_next_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
  assign loc = r_loc;

endmodule
